// File: rtl/line_scanout.sv
// line_scanout: walks one line of words out of the scanline buffer's read
// port and serializes each word MSB-first into pixels, one per pixel_tick.
// A single holding register prefetches the next word so output stays
// gapless at up to one pixel per clock.
// Optional feature macro: LINE_SCANOUT_UNDERRUN_EN adds an 8-bit saturating
// underrun_count output (ticks arriving while busy with no valid pixel).
module line_scanout #(
  parameter int DATA_WIDTH        = 16,
  parameter int BUFFER_ADDR_WIDTH = 8,
  parameter int PIXEL_WIDTH       = 4,
  parameter int LINE_WORDS        = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         line_start,
  input  logic [BUFFER_ADDR_WIDTH-1:0] line_base,
  input  logic                         pixel_tick,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_read_addr,
  input  logic [DATA_WIDTH-1:0]        buf_read_data,
  output logic [PIXEL_WIDTH-1:0]       pixel_data,
  output logic                         pixel_valid,
  output logic                         busy,
  output logic                         line_done
`ifdef LINE_SCANOUT_UNDERRUN_EN
  ,
  output logic [7:0]                   underrun_count
`endif
);

  localparam int PIXELS_PER_WORD = DATA_WIDTH / PIXEL_WIDTH;
  localparam int CW  = $clog2(PIXELS_PER_WORD + 1);
  localparam int WCW = $clog2(LINE_WORDS + 1);
  localparam logic [CW-1:0]  PPW_W        = CW'(PIXELS_PER_WORD);
  localparam logic [WCW-1:0] LINE_WORDS_W = WCW'(LINE_WORDS);

  // Reject parameter sets the serializer cannot handle.
  generate
    if ((DATA_WIDTH % PIXEL_WIDTH) != 0 || PIXELS_PER_WORD < 2) begin : g_bad_pixel_width
      $error("PIXEL_WIDTH must divide DATA_WIDTH with at least two pixels per word");
    end
    if (LINE_WORDS < 1 || LINE_WORDS > (1 << BUFFER_ADDR_WIDTH)) begin : g_bad_line_words
      $error("LINE_WORDS out of range for BUFFER_ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FETCH, ACTIVE} state_t;

  state_t                         state_reg;
  logic [BUFFER_ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]          shift_reg;
  logic [DATA_WIDTH-1:0]          hold_reg;
  logic [CW-1:0]                  pix_cnt_reg;
  logic                           hold_full_reg;
  logic                           hold_pend_reg;   // read issued, data lands next edge
  logic [WCW-1:0]                 issued_reg;      // addresses issued this line
  logic [WCW-1:0]                 loaded_reg;      // words loaded into shift_reg
  logic                           valid_reg;
  logic                           busy_reg;
  logic                           done_reg;

  logic consume;
  logic last_pix;
  logic line_end;
  logic reload;
  logic issue;

  // Per-cycle decisions for the ACTIVE state.
  always_comb begin
    consume  = pixel_tick && valid_reg;
    last_pix = consume && (pix_cnt_reg == CW'(1));
    line_end = last_pix && (loaded_reg == LINE_WORDS_W);
    // Refill from the prefetch word when the current word is used up; the
    // zero-count case only recovers from a stall and never occurs with >=2
    // pixels per word.
    reload   = (state_reg == ACTIVE) && hold_full_reg &&
               (last_pix || (pix_cnt_reg == '0));
    // The next word is requested only as the holding register empties.
    issue    = reload && (issued_reg < LINE_WORDS_W);
  end

  // Scanout FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      shift_reg     <= '0;
      hold_reg      <= '0;
      pix_cnt_reg   <= '0;
      hold_full_reg <= 1'b0;
      hold_pend_reg <= 1'b0;
      issued_reg    <= '0;
      loaded_reg    <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (line_start) begin
            addr_reg      <= line_base;
            issued_reg    <= WCW'(1);
            loaded_reg    <= '0;
            hold_full_reg <= 1'b0;
            hold_pend_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= FETCH;
          end
        end
        FETCH: begin
          shift_reg   <= buf_read_data;
          pix_cnt_reg <= PPW_W;
          valid_reg   <= 1'b1;
          loaded_reg  <= WCW'(1);
          if (issued_reg < LINE_WORDS_W) begin
            addr_reg      <= addr_reg + 1'b1;
            issued_reg    <= issued_reg + 1'b1;
            hold_pend_reg <= 1'b1;
          end
          state_reg <= ACTIVE;
        end
        ACTIVE: begin
          if (hold_pend_reg) begin
            hold_reg      <= buf_read_data;
            hold_full_reg <= 1'b1;
            hold_pend_reg <= 1'b0;
          end
          if (reload) begin
            shift_reg     <= hold_reg;
            pix_cnt_reg   <= PPW_W;
            valid_reg     <= 1'b1;
            hold_full_reg <= 1'b0;
            loaded_reg    <= loaded_reg + 1'b1;
          end else if (consume) begin
            shift_reg   <= shift_reg << PIXEL_WIDTH;
            pix_cnt_reg <= pix_cnt_reg - 1'b1;
            valid_reg   <= (pix_cnt_reg != CW'(1));
          end
          if (issue) begin
            addr_reg      <= addr_reg + 1'b1;
            issued_reg    <= issued_reg + 1'b1;
            hold_pend_reg <= 1'b1;
          end
          if (line_end) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LINE_SCANOUT_UNDERRUN_EN
  logic [7:0] underrun_reg;

  // Saturating count of ticks that found no pixel while a line was running.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_reg <= '0;
    end else if (pixel_tick && busy_reg && !valid_reg && (underrun_reg != 8'hFF)) begin
      underrun_reg <= underrun_reg + 1'b1;
    end
  end

  assign underrun_count = underrun_reg;
`endif

  assign buf_read_addr = addr_reg;
  assign pixel_data    = shift_reg[DATA_WIDTH-1 -: PIXEL_WIDTH];
  assign pixel_valid   = valid_reg;
  assign busy          = busy_reg;
  assign line_done     = done_reg;

endmodule

// File: tb/tb_line_scanout.sv
// Scoreboard bench for line_scanout with a two-word line. Stimulus pushes
// hand-computed pixels and addresses into queues; a negedge monitor pops and
// compares whenever a pixel is consumed or a new read address appears.
module tb_line_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  line_base;
  logic        pixel_tick;
  logic [7:0]  buf_read_addr;
  logic [15:0] buf_read_data;
  logic [3:0]  pixel_data;
  logic        pixel_valid;
  logic        busy;
  logic        line_done;
`ifdef LINE_SCANOUT_UNDERRUN_EN
  logic [7:0]  underrun_count;
`endif

  line_scanout #(
    .DATA_WIDTH(16), .BUFFER_ADDR_WIDTH(8), .PIXEL_WIDTH(4), .LINE_WORDS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .line_start(line_start),
    .line_base(line_base),
    .pixel_tick(pixel_tick),
    .buf_read_addr(buf_read_addr),
    .buf_read_data(buf_read_data),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .busy(busy),
    .line_done(line_done)
`ifdef LINE_SCANOUT_UNDERRUN_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // Line buffer read port: data follows the address on the negedge.
  logic [15:0] mem [0:255];
  always @(negedge clk) buf_read_data <= mem[buf_read_addr];

  int checks = 0;
  int failures = 0;
  int issue_cnt = 0;
  int exp_under = 0;
  logic [3:0] exp_pix [$];
  logic [7:0] exp_addr [$];
  logic [7:0] prev_addr = '0;
  logic       prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: consumed pixels and newly issued read addresses.
  always @(negedge clk) begin
    if (pixel_valid && pixel_tick) begin
      if (exp_pix.size() == 0) check("pixel_unexpected", {28'd0, pixel_data}, 32'hFFFF_FFFF);
      else begin
        logic [3:0] e;
        e = exp_pix.pop_front();
        check("pixel", {28'd0, pixel_data}, {28'd0, e});
        $display("pixel %h (expected %h)", pixel_data, e);
      end
    end
    if (busy && (!prev_busy || buf_read_addr != prev_addr)) begin
      issue_cnt++;
      if (exp_addr.size() == 0) check("addr_unexpected", {24'd0, buf_read_addr}, 32'hFFFF_FFFF);
      else check("read_addr", {24'd0, buf_read_addr}, {24'd0, exp_addr.pop_front()});
    end
    prev_addr = buf_read_addr;
    prev_busy = busy;
  end

  // One line: period = tick spacing, mid_at = cycle of a stray line_start
  // (0 = none), exp_done = iteration at which line_done is expected.
  task automatic run_line(input string name, input logic [7:0] base, input logic [31:0] pix,
                          input logic [7:0] a0, input logic [7:0] a1, input int period,
                          input int mid_at, input int exp_done, input int under_inc);
    int dones;
    int done_cyc;
    int issues0;
    for (int k = 7; k >= 0; k--) exp_pix.push_back(pix[k*4 +: 4]);
    exp_addr.push_back(a0);
    exp_addr.push_back(a1);
    issues0 = issue_cnt;
    dones = 0;
    done_cyc = -1;
    @(posedge clk); #1;
    line_start = 1'b1;
    line_base  = base;
    pixel_tick = (period == 1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      line_start = (cyc == mid_at);
      line_base  = (cyc == mid_at) ? 8'h40 : base;
      pixel_tick = (dones == 0) && ((cyc % period) == (period - 1));
      @(negedge clk);
      if (line_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
    end
    exp_under += under_inc;
    check({name, "_done_count"}, dones, 1);
    check({name, "_done_cycle"}, done_cyc, exp_done);
    check({name, "_issue_count"}, issue_cnt - issues0, 2);
    check({name, "_pixels_left"}, exp_pix.size(), 0);
    check({name, "_addrs_left"}, exp_addr.size(), 0);
`ifdef LINE_SCANOUT_UNDERRUN_EN
    check({name, "_underrun"}, {24'd0, underrun_count}, exp_under);
`endif
    $display("line %s base=%h done_cycle=%0d dones=%0d", name, base, done_cyc, dones);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_addr"},  {24'd0, buf_read_addr}, 32'd0);
    check({name, "_pixel"}, {28'd0, pixel_data}, 32'd0);
    check({name, "_valid"}, {31'd0, pixel_valid}, 32'd0);
    check({name, "_busy"},  {31'd0, busy}, 32'd0);
    check({name, "_done"},  {31'd0, line_done}, 32'd0);
`ifdef LINE_SCANOUT_UNDERRUN_EN
    check({name, "_underrun"}, {24'd0, underrun_count}, 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'h5678;
    mem[8'hFF] = 16'h9ABC;
    mem[8'h00] = 16'hDEF0;
    mem[8'h40] = 16'hAAAA;
    mem[8'h41] = 16'hBBBB;

    reset = 1'b1;
    line_start = 1'b0;
    line_base = 8'h00;
    pixel_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_init");
    @(posedge clk); #1;
    reset = 1'b0;

    // Continuous ticks, tick also high in IDLE and FETCH cycles.
    run_line("continuous", 8'h10, 32'h1234_5678, 8'h10, 8'h11, 1, 0, 10, 1);
    // Address wraps from 0xFF to 0x00.
    run_line("wrap", 8'hFF, 32'h9ABC_DEF0, 8'hFF, 8'h00, 1, 0, 10, 1);
    // Sparse ticks never land in FETCH: no underrun, same pixels.
    run_line("every3", 8'h10, 32'h1234_5678, 8'h10, 8'h11, 3, 0, 24, 0);
    // Stray line_start mid-line must be ignored.
    run_line("midstart", 8'h10, 32'h1234_5678, 8'h10, 8'h11, 1, 3, 10, 1);

    // Reset after three pixels, then replay the whole line.
    for (int k = 7; k >= 0; k--) exp_pix.push_back(4'(k == 7 ? 1 : 8 - k));
    exp_addr.push_back(8'h10);
    exp_addr.push_back(8'h11);
    @(posedge clk); #1;
    line_start = 1'b1;
    line_base  = 8'h10;
    pixel_tick = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      line_start = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    pixel_tick = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_midline");
    check("reset_pixels_consumed", 8 - exp_pix.size(), 3);
    check("reset_addrs_left", exp_addr.size(), 0);
    exp_pix.delete();
    exp_addr.delete();
    exp_under = 0;
    run_line("replay", 8'h10, 32'h1234_5678, 8'h10, 8'h11, 1, 0, 10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
